// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU opcode encodings, legality bound and flag indices.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Highest legal opcode; anything above it is reported as an error.
  localparam logic [3:0] ALU_OP_LAST = 4'b1001;

  localparam int FLAG_LT  = 0;
  localparam int FLAG_LTU = 1;
  localparam int FLAG_EQ  = 2;

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb_if
// Brief    : Requester, shared-ALU and response bundle for alu_share_arb.
//            The slave modport is the arbiter's view.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int NUM_REQ       = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]               req_valid;
  logic [4*NUM_REQ-1:0]             req_op;
  logic [OPERAND_WIDTH*NUM_REQ-1:0] req_a;
  logic [OPERAND_WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]               req_ready;

  logic [3:0]                       alu_op;
  logic [OPERAND_WIDTH-1:0]         alu_operand1;
  logic [OPERAND_WIDTH-1:0]         alu_operand2;
  logic [OPERAND_WIDTH-1:0]         alu_result;
  logic [2:0]                       alu_flags;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_W-1:0]                  rsp_id;
  logic [OPERAND_WIDTH-1:0]         rsp_result;
  logic [2:0]                       rsp_flags;
  logic                             rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_flags, rsp_ready,
    output req_ready, alu_op, alu_operand1, alu_operand2,
           rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_op, alu_operand1, alu_operand2,
           rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector. Searches from last_gnt+1
//            (wrapping) for the first set valid bit.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] valid_i,
  input  wire logic [ID_W-1:0]    last_gnt_i,
  output logic      [NUM_REQ-1:0] gnt_o,
  output logic      [ID_W-1:0]    idx_o,
  output logic                    any_o
);

  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;
  logic            w_hi_any;
  logic            w_lo_any;

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        w_lo_idx = ID_W'(i);
        w_lo_any = 1'b1;
        if (ID_W'(i) > last_gnt_i) begin
          w_hi_idx = ID_W'(i);
          w_hi_any = 1'b1;
        end
      end
    end
    any_o = w_lo_any;
    idx_o = w_hi_any ? w_hi_idx : w_lo_idx;
    gnt_o = w_lo_any ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Brief    : Round-robin time-sharing of one combinational ALU between
//            several requesters, with a single tagged response register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int NUM_REQ       = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input wire logic       clk,
  input wire logic       rst_n,
  alu_share_arb_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [ID_W-1:0]          last_gnt_q;
  logic [ID_W-1:0]          rsp_id_q;
  logic [OPERAND_WIDTH-1:0] rsp_result_q;
  logic [2:0]               rsp_flags_q;
  logic                     rsp_err_q;

  logic [NUM_REQ-1:0]       w_gnt;
  logic [ID_W-1:0]          w_idx;
  logic                     w_any;
  logic                     w_can_grant;
  logic                     w_fire;
  logic [3:0]               w_sel_op;
  logic [OPERAND_WIDTH-1:0] w_sel_a;
  logic [OPERAND_WIDTH-1:0] w_sel_b;
  logic                     w_illegal;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .valid_i    (bus.req_valid),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (w_gnt),
    .idx_o      (w_idx),
    .any_o      (w_any)
  );

  // Free slot, or a full slot that is being drained this very cycle.
  assign w_can_grant = (state_q == ST_EMPTY) || rsp_ready_full();
  assign w_fire      = w_can_grant && w_any;

  function automatic logic rsp_ready_full();
    return (state_q == ST_FULL) && bus.rsp_ready;
  endfunction

  // Select the granted requester's slices; zero when nothing is granted so the ALU never sees X.
  always_comb begin
    w_sel_op = ALU_ADD;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_fire && (w_idx == ID_W'(i))) begin
        w_sel_op = bus.req_op[i*4 +: 4];
        w_sel_a  = bus.req_a[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        w_sel_b  = bus.req_b[i*OPERAND_WIDTH +: OPERAND_WIDTH];
      end
    end
  end

  assign w_illegal = (w_sel_op > ALU_OP_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: any handshake fills the slot; a drain without refill empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (w_fire) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !w_fire) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Outputs: grant, ALU drive and response valid.
  always_comb begin
    bus.req_ready    = w_fire ? w_gnt : '0;
    bus.alu_op       = w_sel_op;
    bus.alu_operand1 = w_sel_a;
    bus.alu_operand2 = w_sel_b;
    bus.rsp_valid    = (state_q == ST_FULL);
  end

  // Response capture and round-robin pointer update on each completed handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q   <= ID_W'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else if (w_fire) begin
      last_gnt_q   <= w_idx;
      rsp_id_q     <= w_idx;
      rsp_result_q <= w_illegal ? '0 : bus.alu_result;
      rsp_flags_q  <= bus.alu_flags;
      rsp_err_q    <= w_illegal;
    end
  end

  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Brief    : Directed self-checking bench for alu_share_arb with a reference
//            combinational ALU attached to the shared ALU port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

  localparam int W = 32;
  localparam int N = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_share_arb_if #(.OPERAND_WIDTH(W), .NUM_REQ(N)) bus ();

  alu_share_arb #(.OPERAND_WIDTH(W), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; illegal opcodes return a marker value the arbiter must squash.
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_result = bus.alu_operand1 + bus.alu_operand2;
      4'b0001: bus.alu_result = bus.alu_operand1 - bus.alu_operand2;
      4'b0010: bus.alu_result = bus.alu_operand1 ^ bus.alu_operand2;
      4'b0011: bus.alu_result = bus.alu_operand1 | bus.alu_operand2;
      4'b0100: bus.alu_result = bus.alu_operand1 & bus.alu_operand2;
      4'b0101: bus.alu_result = bus.alu_operand1 << bus.alu_operand2[4:0];
      4'b0110: bus.alu_result = bus.alu_operand1 >> bus.alu_operand2[4:0];
      4'b0111: bus.alu_result = W'($signed(bus.alu_operand1) >>> bus.alu_operand2[4:0]);
      4'b1000: bus.alu_result = W'($signed(bus.alu_operand1) < $signed(bus.alu_operand2));
      4'b1001: bus.alu_result = W'(bus.alu_operand1 < bus.alu_operand2);
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
    bus.alu_flags[0] = $signed(bus.alu_operand1) < $signed(bus.alu_operand2);
    bus.alu_flags[1] = bus.alu_operand1 < bus.alu_operand2;
    bus.alu_flags[2] = bus.alu_operand1 == bus.alu_operand2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[i*4 +: 4] = op;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #12;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_rsp_flags", bus.rsp_flags, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: pending data but no valid must leave the ALU at add 0,0.
    set_req(0, 4'b0011, 32'h1234, 32'h55);
    set_req(1, 4'b0111, 32'hABCD, 32'h66);
    bus.rsp_ready = 1'b1;
    step();
    chk("idle_req_ready", bus.req_ready, 0);
    chk("idle_alu_op", bus.alu_op, 0);
    chk("idle_alu_a", bus.alu_operand1, 0);
    chk("idle_alu_b", bus.alu_operand2, 0);

    // Contention: req0 sub 9-9, req1 slt -1,1.
    set_req(0, 4'b0001, 32'd9, 32'd9);
    set_req(1, 4'b1000, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 2'b11;
    #1;
    chk("cont_first_ready", bus.req_ready, 2'b01);
    step();
    chk("cont1_valid", bus.rsp_valid, 1);
    chk("cont1_id", bus.rsp_id, 0);
    chk("cont1_result", bus.rsp_result, 0);
    chk("cont1_flags", bus.rsp_flags, 3'b100);
    chk("cont_second_ready", bus.req_ready, 2'b10);
    step();
    chk("cont2_id", bus.rsp_id, 1);
    chk("cont2_result", bus.rsp_result, 1);
    chk("cont2_flags", bus.rsp_flags, 3'b001);
    chk("cont_third_ready", bus.req_ready, 2'b01);
    bus.req_valid = 2'b01;
    step();
    chk("cont3_id", bus.rsp_id, 0);
    chk("cont3_valid", bus.rsp_valid, 1);

    // Backpressure: response held, waiting req1 add 100+23.
    bus.rsp_ready = 1'b0;
    set_req(1, 4'b0000, 32'd100, 32'd23);
    bus.req_valid = 2'b10;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_id", bus.rsp_id, 0);
      chk("bp_rsp_result", bus.rsp_result, 0);
      chk("bp_rsp_flags", bus.rsp_flags, 3'b100);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 2'b10);
    chk("bp_release_alu_a", bus.alu_operand1, 100);
    chk("bp_release_alu_b", bus.alu_operand2, 23);
    step();
    chk("bp_new_valid", bus.rsp_valid, 1);
    chk("bp_new_id", bus.rsp_id, 1);
    chk("bp_new_result", bus.rsp_result, 123);
    chk("bp_new_flags", bus.rsp_flags, 3'b000);
    bus.req_valid = 2'b00;
    step();
    chk("drain_valid", bus.rsp_valid, 0);

    // Single op: add 5+7 on req0.
    set_req(0, 4'b0000, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    #1;
    chk("single_ready", bus.req_ready, 2'b01);
    step();
    chk("single_valid", bus.rsp_valid, 1);
    chk("single_id", bus.rsp_id, 0);
    chk("single_result", bus.rsp_result, 12);
    chk("single_flags", bus.rsp_flags, 3'b011);
    chk("single_err", bus.rsp_err, 0);
    bus.req_valid = 2'b00;
    step();
    chk("single_drain", bus.rsp_valid, 0);

    // Illegal opcode: result squashed, flags still captured.
    set_req(0, 4'b1100, 32'd3, 32'd4);
    bus.req_valid = 2'b01;
    step();
    chk("illegal_err", bus.rsp_err, 1);
    chk("illegal_result", bus.rsp_result, 0);
    chk("illegal_flags", bus.rsp_flags, 3'b011);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    step();
    chk("illegal_hold_valid", bus.rsp_valid, 1);

    // Reset while full drops the response immediately.
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.rsp_valid, 0);
    chk("midrst_err", bus.rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 4'b0000, 32'd1, 32'd2);
    set_req(1, 4'b0000, 32'd3, 32'd4);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1;
    chk("postrst_ready", bus.req_ready, 2'b01);
    step();
    chk("postrst_id", bus.rsp_id, 0);
    chk("postrst_result", bus.rsp_result, 3);

    bus.req_valid = 2'b00;
    #1;
    chk("idle2_alu_op", bus.alu_op, 0);
    chk("idle2_alu_a", bus.alu_operand1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter that time-shares the single combinational execute ALU between several requesters: the EX-stage integer path, the branch-compare path and the iterative M-extension unit. The arbiter:

- accepts one valid/ready operation per cycle;
- drives the shared ALU's opcode and operand inputs for the granted requester;
- captures the ALU result and flags into a single response register, tagged with the requester id.

It sits between the EX-stage requesters and the ALU instance, which remains a pure combinational datapath.

## Interface

Parameters:

- OPERAND_WIDTH, 32: operand and result width; must match the ALU.
- NUM_REQ, 2: number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ): width of the requester id.

Ports:

- clk  input  1  single clock; all state is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_op  input  4*NUM_REQ  per-requester ALU opcode; slice i belongs to requester i.
- req_a  input  OPERAND_WIDTH*NUM_REQ  per-requester operand1.
- req_b  input  OPERAND_WIDTH*NUM_REQ  per-requester operand2.
- req_ready  output  NUM_REQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
- alu_op  output  4  opcode to the shared ALU.
- alu_operand1  output  OPERAND_WIDTH  operand1 to the ALU.
- alu_operand2  output  OPERAND_WIDTH  operand2 to the ALU.
- alu_result  input  OPERAND_WIDTH  combinational result from the ALU.
- alu_flags  input  3  ALU flags: [0] signed less-than, [1] unsigned less-than, [2] equal.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_result  output  OPERAND_WIDTH  registered result.
- rsp_flags  output  3  registered flags.
- rsp_err  output  1  the op was an illegal opcode (4'b1010..4'b1111).

## Operation

- FSM with two states:
  - EMPTY: the response register is free.
  - FULL: rsp_valid=1, waiting for rsp_ready.
- Grant is allowed (can_grant) when state is EMPTY, or when state is FULL and rsp_ready=1 in the same cycle (drain-and-refill).
- Round-robin selection:
  - Pointer last_gnt holds the index of the most recent grant.
  - The search starts at last_gnt+1, modulo NUM_REQ, and takes the first requester with req_valid set.
  - last_gnt updates only on a completed handshake.
- req_ready is combinational: one-hot of the selected index when can_grant and any req_valid is set; otherwise all zero.
  - req_ready must never depend on rsp_valid alone. Use can_grant.
- ALU drive:
  - When a grant occurs, alu_op/alu_operand1/alu_operand2 are the granted requester's slices.
  - Otherwise they are forced to op 4'b0000 (add) with zero operands, so the ALU never sees X.
- Capture on a handshake edge:
  - rsp_result ← alu_result, rsp_flags ← alu_flags, rsp_id ← granted index, rsp_err ← (op ≥ 4'b1010).
  - If rsp_err=1, rsp_result is forced to 0; flags are still captured.
  - State becomes FULL.
- Drain:
  - FULL & rsp_ready with no new grant → EMPTY.
  - FULL & rsp_ready with a new grant → stays FULL with the new data.
- Opcode legality: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu; all others are illegal.
- Requesters must hold req_op/req_a/req_b stable while req_valid=1 and not granted. The arbiter does not check this.

## Timing

- Reset (asynchronous assert, synchronous deassert handled upstream) sets:
  - state=EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0;
  - last_gnt=NUM_REQ-1, so requester 0 wins first.
- Reset mid-FULL discards the pending response; rsp_valid drops immediately on rst_n low.
- Latency: the request is granted in cycle t; rsp_valid=1 from cycle t+1.
- Throughput: one op per cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0 in FULL, req_ready=0 and the response register holds every field stable.
- Simultaneous requests: exactly one grant per cycle; the others wait with req_ready=0.
- Pointer wrap: after granting NUM_REQ-1, the next search starts at index 0.
- No combinational path from rsp_ready to rsp_* outputs. The path rsp_ready → req_ready → alu_* is allowed.

## Structure

- Shared package alu_pkg:
  - ALU opcode localparams (ALU_ADD … ALU_SLTU);
  - ALU_OP_LAST=4'b1001, used for the legality check;
  - flag bit indices FLAG_LT=0, FLAG_LTU=1, FLAG_EQ=2.
- One sub-module, rr_pick:
  - combinational round-robin selector;
  - inputs: valid vector and last_gnt;
  - outputs: one-hot grant and encoded index.
- The ALU stays external. The arbiter does not instantiate it, so the bench can connect a reference ALU directly.

## Test plan

- Single op: req_valid=01, op=0000, a=5, b=7 → req_ready=01 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_flags=3'b011.
- Contention: both valid, sub 9-9 on req0 and slt -1,1 on req1, rsp_ready=1.
  - Cycle 1: rsp_id=0, result=0, flags[2]=1.
  - Cycle 2: rsp_id=1, result=1, flags[0]=1.
  - A third simultaneous request then grants req0 (fairness).
- Backpressure: hold rsp_ready=0 for 4 cycles after one response → req_ready=00 and rsp_* stable throughout; raise rsp_ready → the waiting request is granted that same cycle and rsp_valid stays 1 with new data.
- Illegal op: op=4'b1100, a=3, b=4 → rsp_err=1, rsp_result=0, rsp_flags=3'b011.
- Reset mid-operation: assert rst_n=0 while FULL → rsp_valid=0 immediately. After release, simultaneous requests grant req0 first.
- Idle drive: no req_valid → alu_op=0000 and alu_operand1/alu_operand2=0 every cycle.
